sound_cue_sequencer: RTL and testbench
======================================

// Module: sound_cue_sequencer
// PURPOSE
// Driving end of the APU trigger interface. Accepts numbered sound cues from game
// logic over a valid/ready port, queues them, expands each cue from a fixed table
// into up to 3 timed steps, and drives saw/square/noise trigger levels to the APU.
// All step durations are counted in frames via frame_tick.
// PARAMETERS
// QUEUE_DEPTH  4  cue FIFO entries; must be a power of 2, >= 2
// DUR_BITS     6  width of the step duration counter, in frames
// PORTS
// clk             in   1   clock; all logic on posedge
// reset           in   1   synchronous, active-high
// frame_tick      in   1   one-cycle pulse per video frame (at x==0 && y==0)
// cue_valid       in   1   cue request present
// cue_code        in   3   cue number, 0..7
// cue_ready       out  1   cue accepted on an edge where cue_valid && cue_ready
// stop            in   1   flush the queue and silence all triggers
// saw_trigger     out  1   level to APU saw channel
// square_trigger  out  1   level to APU square channel
// noise_trigger   out  1   level to APU noise channel
// busy            out  1   high while state != IDLE or queue not empty
// queue_count     out  clog2(QUEUE_DEPTH)+1  entries currently queued
// dropped         out  1   one-cycle pulse when a cue is discarded (SOUND_CUE_DROP_EN only)
// BEHAVIOUR
// - Reset: FIFO empty, state IDLE, all triggers 0, busy 0, queue_count 0, dropped 0.
//   cue_ready is 1 while reset is not asserted and the queue is not full.
// - Cue table, step = {mask saw/sq/noise, frames}; a 0-frame step ends the cue:
//   0 none: ends immediately, no trigger output | 1 shoot: S 4 | 2 hit: N 8
//   3 explode: Q+N 16, N 16 | 4 pickup: Q 4, silent 2, Q 4 | 5 die: S+Q 12, N 20
//   6 level-up: Q 8, S 8, Q 8 | 7 blip: Q 2
// - States: IDLE -> LOAD -> PLAY -> (LOAD of next step | IDLE).
//   IDLE: queue not empty -> pop the head entry, go to LOAD.
//   LOAD: read the table step and register mask and duration. A 0-frame step goes to IDLE.
//   PLAY: triggers = registered mask. Each frame_tick decrements the counter.
//   A frame_tick with counter == 1 advances the step index and goes to LOAD.
// - Latency: a cue accepted on edge k into an empty queue while IDLE drives triggers from edge k+2.
//   A step lasts exactly `frames` frame_ticks. Triggers are 0 in LOAD and IDLE, so there is
//   a 1-cycle gap between steps and between consecutive cues.
// - A frame_tick on the edge that enters PLAY is not counted. frame_tick is ignored outside PLAY.
// - FIFO: push and pop on the same edge are both honoured, and the count is unchanged.
//   No bypass: a cue is always stored before it is popped.
// - stop (level, sampled each edge): empties the FIFO, state -> IDLE, triggers 0 on the next edge.
//   cue_ready = 0 while stop = 1, so no push happens that cycle. stop overrides every other event.
// - Reset asserted mid-cue returns to reset values on that edge. No partial cue resumes afterwards.
// - All trigger outputs are registered, with no combinational path from inputs to triggers.
// CONFIGURATION
// SOUND_CUE_DROP_EN defined:
// - cue_ready = !stop and ignores FIFO fullness.
// - A push to a full queue is discarded, dropped pulses 1 cycle, and the FIFO is unchanged.
//   A push on the same edge as a pop is never dropped.
// SOUND_CUE_DROP_EN undefined:
// - cue_ready = !stop && queue_count < QUEUE_DEPTH, which is standard backpressure.
// - dropped is tied to 0.
// TESTING
// - Reset, then cue 1 accepted at edge k -> saw_trigger=1 from edge k+2 until the 4th later frame_tick,
//   then 0; busy falls the same edge.
// - Cue 4 -> square high 4 frames, low (silent step) 2 frames + gaps, square high 4 frames, then IDLE.
// - Push 5 cues back-to-back while playing cue 3, QUEUE_DEPTH=4:
//   - Without the macro: cue_ready falls when queue_count=4.
//   - With the macro: the 5th push gives a dropped pulse, and queue_count stays 4.
// - Assert stop mid-cue 5 with 2 cues queued -> next edge: all triggers 0, queue_count 0, busy 0,
//   cue_ready 0 while stop=1.
// - frame_tick coincident with the PLAY entry edge -> the step still lasts exactly its full frame count.
// - Cue 0, then cue 7 -> no trigger for cue 0; square_trigger high for exactly 2 frames.

Source files
------------

// File: rtl/sound_cue_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sound_cue_sequencer: queues numbered sound cues and expands each one into    |
// | timed saw/square/noise trigger steps. Optional build macro: SOUND_CUE_DROP_EN |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module sound_cue_sequencer #(
    parameter int QUEUE_DEPTH = 4,
    parameter int DUR_BITS    = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_tick,
    input  logic                         cue_valid,
    input  logic [2:0]                   cue_code,
    output logic                         cue_ready,
    input  logic                         stop,
    output logic                         saw_trigger,
    output logic                         square_trigger,
    output logic                         noise_trigger,
    output logic                         busy,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count,
    output logic                         dropped
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            cue_q, cue_d;
    logic [1:0]            step_q, step_d;
    logic [DUR_BITS-1:0]   dur_q, dur_d;
    logic [2:0]            trig_q, trig_d;
    logic                  busy_q, busy_d;
    logic [2:0]            fifo_q [QUEUE_DEPTH];
    logic [2:0]            fifo_d [QUEUE_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  full, empty, push, pop, cue_done;
    logic [2:0]            head;
    logic [7:0]            cur_step, nxt_step;

    // Entry = {saw, square, noise, frames[4:0]}; an all-zero entry terminates the cue.
    function automatic logic [7:0] cue_step(input logic [2:0] cue, input logic [1:0] step);
        logic [7:0] s;
        s = 8'h00;
        case ({cue, step})
            {3'd1, 2'd0}: s = {3'b100, 5'd4};
            {3'd2, 2'd0}: s = {3'b001, 5'd8};
            {3'd3, 2'd0}: s = {3'b011, 5'd16};
            {3'd3, 2'd1}: s = {3'b001, 5'd16};
            {3'd4, 2'd0}: s = {3'b010, 5'd4};
            {3'd4, 2'd1}: s = {3'b000, 5'd2};
            {3'd4, 2'd2}: s = {3'b010, 5'd4};
            {3'd5, 2'd0}: s = {3'b110, 5'd12};
            {3'd5, 2'd1}: s = {3'b001, 5'd20};
            {3'd6, 2'd0}: s = {3'b010, 5'd8};
            {3'd6, 2'd1}: s = {3'b100, 5'd8};
            {3'd6, 2'd2}: s = {3'b010, 5'd8};
            {3'd7, 2'd0}: s = {3'b010, 5'd2};
            default:      s = 8'h00;
        endcase
        return s;
    endfunction

    assign full  = (count_q == CNT_W'(QUEUE_DEPTH));
    assign empty = (count_q == '0);
    assign head  = fifo_q[rd_ptr_q];

`ifdef SOUND_CUE_DROP_EN
    logic dropped_q, dropped_d;

    assign cue_ready = !reset && !stop;
    assign dropped_d = cue_valid && cue_ready && full && !pop;
    assign dropped   = dropped_q;

    always_ff @(posedge clk) begin
        if (reset) dropped_q <= 1'b0;
        else       dropped_q <= dropped_d;
    end
`else
    assign cue_ready = !reset && !stop && !full;
    assign dropped   = 1'b0;
`endif

    // A push into a full queue only lands when the head is popped on the same edge.
    assign push = cue_valid && cue_ready && (!full || pop);

    always_comb begin
        state_d  = state_q;
        cue_d    = cue_q;
        step_d   = step_q;
        dur_d    = dur_q;
        trig_d   = 3'b000;
        pop      = 1'b0;
        cue_done = 1'b0;
        cur_step = cue_step(cue_q, step_q);
        nxt_step = cue_step(cue_q, step_q + 2'd1);

        case (state_q)
            ST_IDLE: cue_done = 1'b1;
            ST_LOAD: begin
                if (cur_step == 8'h00) begin
                    cue_done = 1'b1;
                end else begin
                    trig_d  = cur_step[7:5];
                    dur_d   = DUR_BITS'(cur_step[4:0]);
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                trig_d = trig_q;
                if (frame_tick) begin
                    if (dur_q == DUR_BITS'(1)) begin
                        trig_d = 3'b000;
                        if (nxt_step == 8'h00) begin
                            cue_done = 1'b1;
                        end else begin
                            step_d  = step_q + 2'd1;
                            state_d = ST_LOAD;
                        end
                    end else begin
                        dur_d = dur_q - DUR_BITS'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Finishing a cue chains straight into the next queued one so the gap stays one cycle.
        if (cue_done) begin
            if (!empty) begin
                pop     = 1'b1;
                cue_d   = head;
                step_d  = 2'd0;
                state_d = ST_LOAD;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (stop) begin
            state_d = ST_IDLE;
            trig_d  = 3'b000;
            pop     = 1'b0;
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (stop) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = cue_code;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        busy_d = (state_d != ST_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
        if (reset) begin
            state_q  <= ST_IDLE;
            cue_q    <= 3'd0;
            step_q   <= 2'd0;
            dur_q    <= '0;
            trig_q   <= 3'b000;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cue_q    <= cue_d;
            step_q   <= step_d;
            dur_q    <= dur_d;
            trig_q   <= trig_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign saw_trigger    = trig_q[2];
    assign square_trigger = trig_q[1];
    assign noise_trigger  = trig_q[0];
    assign busy           = busy_q;
    assign queue_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_sound_cue_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_sound_cue_sequencer: directed bench with a trigger-segment scoreboard.    |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_sound_cue_sequencer;

    localparam int QD = 4;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       frame_tick = 1'b0;
    logic       cue_valid  = 1'b0;
    logic [2:0] cue_code   = 3'd0;
    logic       stop       = 1'b0;
    logic       cue_ready, saw_trigger, square_trigger, noise_trigger, busy, dropped;
    logic [2:0] queue_count;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int mask;
        int len;
        int low;
    } seg_t;
    seg_t exp_q[$];

    bit tick_auto   = 1'b1;
    bit tick_manual = 1'b0;
    int cyc         = 0;

    sound_cue_sequencer #(
        .QUEUE_DEPTH(QD),
        .DUR_BITS   (6)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .cue_valid     (cue_valid),
        .cue_code      (cue_code),
        .cue_ready     (cue_ready),
        .stop          (stop),
        .saw_trigger   (saw_trigger),
        .square_trigger(square_trigger),
        .noise_trigger (noise_trigger),
        .busy          (busy),
        .queue_count   (queue_count),
        .dropped       (dropped)
    );

    always #5 clk = ~clk;

    // Frame ticks every 5 cycles, so a tick never lands in the one-cycle gaps.
    always begin
        @(negedge clk);
        #1;
        cyc++;
        frame_tick = (tick_auto && (cyc % 5 == 0)) || tick_manual;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_seg(input int mask, input int len, input int low);
        seg_t s;
        s.mask = mask;
        s.len  = len;
        s.low  = low;
        exp_q.push_back(s);
    endtask

    // Mask encoding {saw, square, noise}; low = frame ticks seen while silent before the segment.
    task automatic push_cue_exp(input int code, input int low0);
        case (code)
            1: push_seg(4, 4, low0);
            2: push_seg(1, 8, low0);
            3: begin push_seg(3, 16, low0); push_seg(1, 16, 0); end
            4: begin push_seg(2, 4, low0);  push_seg(2, 4, 2);  end
            5: begin push_seg(6, 12, low0); push_seg(1, 20, 0); end
            6: begin push_seg(2, 8, low0);  push_seg(4, 8, 0); push_seg(2, 8, 0); end
            7: push_seg(2, 2, low0);
            default: ;
        endcase
    endtask

    task automatic check_seg(input int mask, input int len, input int low);
        seg_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_segment_mask", mask, 0);
        end else begin
            e = exp_q.pop_front();
            chk("seg_mask", mask, e.mask);
            if (e.len >= 0) chk("seg_frames", len, e.len);
            if (e.low >= 0) chk("seg_gap_ticks", low, e.low);
        end
    endtask

    logic [2:0] m_prev = 3'b000;
    logic [2:0] m_cur;
    logic       m_tk;
    int         m_seg = 0, m_low = 0, m_low_start = 0;

    always begin
        @(posedge clk);
        m_tk = frame_tick;
        #1;
        m_cur = {saw_trigger, square_trigger, noise_trigger};
        if (reset) begin
            m_prev = 3'b000;
            m_low  = 0;
        end else begin
            if (m_prev != 3'b000) m_seg += int'(m_tk);
            else                  m_low += int'(m_tk);
            if (m_cur != m_prev) begin
                if (m_prev != 3'b000) check_seg(int'(m_prev), m_seg, m_low_start);
                m_low_start = m_low;
                m_seg       = 0;
                m_low       = 0;
            end
            m_prev = m_cur;
        end
    end

    task automatic wait_trig(input logic [2:0] m, input int max, input string tag);
        int i;
        i = 0;
        while ({saw_trigger, square_trigger, noise_trigger} !== m && i < max) begin
            @(negedge clk);
            i++;
        end
        chk(tag, {saw_trigger, square_trigger, noise_trigger}, m);
    endtask

    task automatic wait_idle(input int max, input string tag);
        int i;
        i = 0;
        while (busy !== 1'b0 && i < max) begin
            @(negedge clk);
            i++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic send_cue(input logic [2:0] code);
        int i;
        i = 0;
        while (cue_ready !== 1'b1 && i < 500) begin
            @(negedge clk);
            i++;
        end
        chk("send_ready", cue_ready, 1);
        cue_valid = 1'b1;
        cue_code  = code;
        @(negedge clk);
        cue_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int codes[5];
        codes = '{7, 2, 0, 1, 6};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_trig", {saw_trigger, square_trigger, noise_trigger}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", queue_count, 0);
        chk("rst_dropped", dropped, 0);
        chk("rst_ready", cue_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", cue_ready, 1);

        // Cue 1: two-edge latency, four frames of saw, busy falls with the trigger
        cue_valid = 1'b1;
        cue_code  = 3'd1;
        push_cue_exp(1, -1);
        @(negedge clk);
        cue_valid = 1'b0;
        chk("k_count", queue_count, 1);
        chk("k_busy", busy, 1);
        chk("k_trig", {saw_trigger, square_trigger, noise_trigger}, 0);
        @(negedge clk);
        chk("k1_trig", {saw_trigger, square_trigger, noise_trigger}, 0);
        chk("k1_count", queue_count, 0);
        @(negedge clk);
        chk("k2_saw", saw_trigger, 1);
        for (int i = 0; i < 100 && saw_trigger === 1'b1; i++) @(negedge clk);
        chk("cue1_saw_end", saw_trigger, 0);
        chk("cue1_busy_end", busy, 0);

        // Cue 4: square, silent step, square
        send_cue(3'd4);
        push_cue_exp(4, -1);
        wait_idle(300, "cue4_idle");

        // Fill the queue while cue 3 plays
        send_cue(3'd3);
        push_cue_exp(3, -1);
        wait_trig(3'b011, 20, "cue3_start");
        for (int i = 0; i < 5; i++) begin
            cue_valid = 1'b1;
            cue_code  = 3'(codes[i]);
            if (i < QD) push_cue_exp(codes[i], 0);
`ifndef SOUND_CUE_DROP_EN
            if (i == QD) begin
                chk("ready_low_full", cue_ready, 0);
                chk("count_full", queue_count, QD);
            end
`endif
            @(negedge clk);
        end
        cue_valid = 1'b0;
        chk("count_after_fill", queue_count, QD);
`ifdef SOUND_CUE_DROP_EN
        chk("drop_pulse", dropped, 1);
        @(negedge clk);
        chk("drop_pulse_end", dropped, 0);
        chk("count_after_drop", queue_count, QD);
`endif
        wait_idle(600, "queue_drain_idle");
        chk("queue_drained", queue_count, 0);

        // Stop mid cue 5 with two cues queued
        send_cue(3'd5);
        push_seg(6, -1, -1);
        wait_trig(3'b110, 20, "cue5_start");
        send_cue(3'd7);
        send_cue(3'd7);
        chk("count_two", queue_count, 2);
        repeat (10) @(negedge clk);
        stop      = 1'b1;
        cue_valid = 1'b1;
        cue_code  = 3'd7;
        #1;
        chk("stop_ready", cue_ready, 0);
        @(negedge clk);
        chk("stop_trig", {saw_trigger, square_trigger, noise_trigger}, 0);
        chk("stop_count", queue_count, 0);
        chk("stop_busy", busy, 0);
        chk("stop_ready_held", cue_ready, 0);
        @(negedge clk);
        chk("stop_no_push", queue_count, 0);
        stop      = 1'b0;
        cue_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("stop_no_resume_busy", busy, 0);
        chk("stop_no_resume_trig", {saw_trigger, square_trigger, noise_trigger}, 0);

        // Frame tick on the edge that enters PLAY is not counted
        tick_auto = 1'b0;
        repeat (2) @(negedge clk);
        cue_valid = 1'b1;
        cue_code  = 3'd7;
        push_cue_exp(7, -1);
        @(negedge clk);
        cue_valid = 1'b0;
        @(negedge clk);
        tick_manual = 1'b1;
        @(negedge clk);
        tick_manual = 1'b0;
        chk("entry_tick_sq_on", square_trigger, 1);
        @(negedge clk);
        tick_manual = 1'b1;
        @(negedge clk);
        tick_manual = 1'b0;
        chk("one_tick_sq_on", square_trigger, 1);
        @(negedge clk);
        tick_manual = 1'b1;
        @(negedge clk);
        tick_manual = 1'b0;
        chk("two_ticks_sq_off", square_trigger, 0);
        chk("two_ticks_idle", busy, 0);
        tick_auto = 1'b1;

        // Cue 0 is silent, cue 7 follows with two frames of square
        send_cue(3'd0);
        chk("cue0_silent", {saw_trigger, square_trigger, noise_trigger}, 0);
        send_cue(3'd7);
        push_cue_exp(7, -1);
        wait_idle(100, "cue0_7_idle");

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
